// File: rtl/glue_bus_ctrl_pkg.sv
// glue_pkg: shared definitions for the 68000 glue bus controller.
//   state_e  - controller states (IDLE, WAIT, ACK, BERR)
//   FC_IACK  - function code that identifies an interrupt-acknowledge cycle
//   WCNT_W   - width of the per-region internal wait-state counter
package glue_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2,
      ST_BERR = 2'd3
   } state_e;

   localparam logic [2:0] FC_IACK = 3'b111;
   localparam int         WCNT_W  = 4;

endpackage

// File: rtl/glue_bus_ctrl_if.sv
// glue_bus_ctrl_if: 68000-side bus signals of the glue controller.
//   master modport: CPU/peripheral side, drives strobes, address, fc, ext_dtack_n
//   slave modport : controller side, drives chip selects, dtack_n, berr_n,
//                   byte-lane strobes and busy
interface glue_bus_ctrl_if #(
   parameter int NUM_CS = 4,
   parameter int ADDR_W = 6
);
   logic              as_n;
   logic              rw;
   logic              lds_n;
   logic              uds_n;
   logic [2:0]        fc;
   logic [ADDR_W-1:0] addr_upper;
   logic [NUM_CS-1:0] ext_dtack_n;

   logic [NUM_CS-1:0] cs_n;
   logic              dtack_n;
   logic              berr_n;
   logic              lord_n;
   logic              lowr_n;
   logic              uprd_n;
   logic              upwr_n;
   logic              busy;

   modport master (
      output as_n, rw, lds_n, uds_n, fc, addr_upper, ext_dtack_n,
      input  cs_n, dtack_n, berr_n, lord_n, lowr_n, uprd_n, upwr_n, busy
   );

   modport slave (
      input  as_n, rw, lds_n, uds_n, fc, addr_upper, ext_dtack_n,
      output cs_n, dtack_n, berr_n, lord_n, lowr_n, uprd_n, upwr_n, busy
   );
endinterface

// File: rtl/glue_bus_timer.sv
// glue_bus_timer: bus-cycle watchdog.
//   clk, rst   - clock, synchronous active-high reset
//   clear_i    - forces the count to zero
//   en_i       - counts one cycle; the count saturates at LIMIT-1
//   expired_o  - high on the edge at which the count reaches LIMIT-1
module glue_bus_timer #(
   parameter int LIMIT = 64,
   parameter int W     = $clog2(LIMIT)
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);
   logic [W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         count_q <= '0;
      end else if (en_i && (count_q != W'(LIMIT - 1))) begin
         count_q <= count_q + 1'b1;
      end
   end

   // Flag the edge that takes the count to LIMIT-1 so the controller can
   // react on that same edge rather than one cycle later.
   assign expired_o = en_i && (count_q == W'(LIMIT - 2));

endmodule

// File: rtl/glue_bus_ctrl.sv
// glue_bus_ctrl: 68000 address decoder / DTACK / BERR generator.
//   clk, rst - clock, synchronous active-high reset
//   bus      - glue_bus_ctrl_if.slave: strobes, fc, addr_upper, ext_dtack_n in;
//              registered cs_n/dtack_n/berr_n, combinational byte-lane
//              strobes and busy out
module glue_bus_ctrl
   import glue_pkg::*;
#(
   parameter int                       NUM_CS  = 4,
   parameter int                       ADDR_W  = 6,
   parameter logic [NUM_CS*ADDR_W-1:0] CS_BASE = {6'b111011, 6'b111010, 6'b001111, 6'b000000},
   parameter logic [NUM_CS*ADDR_W-1:0] CS_MASK = {6'h3F, 6'h3F, 6'h0F, 6'h07},
   parameter logic [NUM_CS*WCNT_W-1:0] CS_WAIT = {4'd0, 4'd0, 4'd1, 4'd0},
   parameter logic [NUM_CS-1:0]        CS_EXT  = 4'b1100,
   parameter int                       TIMEOUT = 64
) (
   input logic            clk,
   input logic            rst,
   glue_bus_ctrl_if.slave bus
);
   localparam int IDX_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

   state_e              state_q;
   logic [IDX_W-1:0]    idx_q;
   logic [WCNT_W-1:0]   wcnt_q;
   logic [NUM_CS-1:0]   cs_n_q;
   logic                dtack_n_q;
   logic                berr_n_q;
   logic                as_hi_q;   // as_n was high at the previous edge

   logic [NUM_CS-1:0]   hit;
   logic                hit_any;
   logic [IDX_W-1:0]    hit_idx;
   logic [WCNT_W-1:0]   hit_wait;
   logic                ext_ok;
   logic                wd_expired;
   logic                cycle_start;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CS; gi++) begin : g_dec
         assign hit[gi] = ((bus.addr_upper ^ CS_BASE[gi*ADDR_W +: ADDR_W])
                           & CS_MASK[gi*ADDR_W +: ADDR_W]) == '0;
      end
   endgenerate

   // Scan downwards so the lowest hitting region ends up selected.
   always_comb begin
      hit_idx = '0;
      for (int i = NUM_CS - 1; i >= 0; i--) begin
         if (hit[i]) hit_idx = IDX_W'(i);
      end
      hit_any  = |hit;
      hit_wait = CS_WAIT[hit_idx*WCNT_W +: WCNT_W];
   end

   assign ext_ok = !CS_EXT[idx_q] || !bus.ext_dtack_n[idx_q];

   // Only a falling as_n starts a cycle; as_hi_q is cleared by reset so a
   // strobe still held low across reset is not treated as a new cycle.
   assign cycle_start = !bus.as_n && as_hi_q && (bus.fc != FC_IACK);

   glue_bus_timer #(
      .LIMIT (TIMEOUT)
   ) u_wd (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (state_q == ST_IDLE),
      .en_i      (state_q != ST_IDLE),
      .expired_o (wd_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         wcnt_q    <= '0;
         cs_n_q    <= '1;
         dtack_n_q <= 1'b1;
         berr_n_q  <= 1'b1;
         as_hi_q   <= 1'b0;
      end else begin
         as_hi_q <= bus.as_n;
         case (state_q)
            ST_IDLE: begin
               if (cycle_start) begin
                  if (hit_any) begin
                     state_q <= ST_WAIT;
                     idx_q   <= hit_idx;
                     wcnt_q  <= hit_wait;
                     cs_n_q  <= ~(NUM_CS'(1) << hit_idx);
                  end else begin
                     state_q  <= ST_BERR;
                     berr_n_q <= 1'b0;
                  end
               end
            end
            ST_WAIT: begin
               // Abort beats acknowledge, acknowledge beats timeout.
               if (bus.as_n) begin
                  state_q <= ST_IDLE;
                  cs_n_q  <= '1;
               end else if ((wcnt_q == '0) && ext_ok) begin
                  state_q   <= ST_ACK;
                  dtack_n_q <= 1'b0;
               end else if (wd_expired) begin
                  state_q  <= ST_BERR;
                  berr_n_q <= 1'b0;
               end else if (wcnt_q != '0) begin
                  wcnt_q <= wcnt_q - 1'b1;
               end
            end
            ST_ACK, ST_BERR: begin
               if (bus.as_n) begin
                  state_q   <= ST_IDLE;
                  cs_n_q    <= '1;
                  dtack_n_q <= 1'b1;
                  berr_n_q  <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.cs_n    = cs_n_q;
   assign bus.dtack_n = dtack_n_q;
   assign bus.berr_n  = berr_n_q;
   assign bus.busy    = (state_q != ST_IDLE);

   assign bus.lowr_n = bus.rw | bus.lds_n;
   assign bus.lord_n = ~bus.rw | bus.lds_n;
   assign bus.upwr_n = bus.rw | bus.uds_n;
   assign bus.uprd_n = ~bus.rw | bus.uds_n;

endmodule
